conf_ctrl: RTL and testbench

CONF_CTRL -- requirements
Module: conf_ctrl

---
 rtl/conf_ctrl.sv | 125 ++++++++++++
 tb/tb_conf_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conf_ctrl.sv
// UART configuration-frame controller: collects NUM_BYTES received bytes, loads them
// into the configuration register and optionally echoes the loaded frame back over TX.
module conf_ctrl #(
   parameter int NUM_BYTES = 11,
   parameter int TIMEOUT   = 1000000,
   parameter bit ECHO      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_dv,
   input  logic tx_busy,
   output logic tx_start,
   output logic shift_rxregs,
   output logic load_confregs,
   output logic load_txregs,
   output logic shift_txregs,
   output logic frame_done,
   output logic frame_err,
   output logic overrun,
   output logic busy
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, RX, LOAD, TXLOAD, TXREQ, TXWAIT_HI, TXWAIT_LO, TXSHIFT
   } state_t;

   state_t          state;
   logic [CW-1:0]   byte_cnt;
   logic [CW-1:0]   tx_cnt;
   logic [TW-1:0]   timer;

   // Pulses are registered, so each one is high during the state it belongs to.
   // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         tx_cnt        <= '0;
         timer         <= '0;
         tx_start      <= 1'b0;
         shift_rxregs  <= 1'b0;
         load_confregs <= 1'b0;
         load_txregs   <= 1'b0;
         shift_txregs  <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         tx_start      <= 1'b0;
         shift_rxregs  <= 1'b0;
         load_confregs <= 1'b0;
         load_txregs   <= 1'b0;
         shift_txregs  <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;

         case (state)
            IDLE, RX: begin
               if (state == RX && byte_cnt == LAST_BYTE) begin
                  // Frame complete: a byte arriving now has nowhere to go.
                  state         <= LOAD;
                  load_confregs <= 1'b1;
                  frame_done    <= 1'b1;
                  byte_cnt      <= '0;
                  timer         <= '0;
                  overrun       <= rx_dv;
               end else if (rx_dv) begin
                  // A byte on the expiry cycle wins over the timeout.
                  state        <= RX;
                  shift_rxregs <= 1'b1;
                  byte_cnt     <= byte_cnt + 1'b1;
                  timer        <= '0;
               end else if (state == RX && byte_cnt != '0) begin
                  if (timer == TIMER_MAX) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                     byte_cnt  <= '0;
                     timer     <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            LOAD: begin
               if (ECHO) begin
                  state       <= TXLOAD;
                  load_txregs <= 1'b1;
                  tx_cnt      <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            TXLOAD: state <= TXREQ;
            TXREQ: begin
               if (!tx_busy) begin
                  state    <= TXWAIT_HI;
                  tx_start <= 1'b1;
               end
            end
            TXWAIT_HI: if (tx_busy) state <= TXWAIT_LO;
            TXWAIT_LO: begin
               if (!tx_busy) begin
                  state        <= TXSHIFT;
                  shift_txregs <= 1'b1;
                  tx_cnt       <= tx_cnt + 1'b1;
               end
            end
            TXSHIFT: state <= (tx_cnt == LAST_BYTE) ? IDLE : TXREQ;
            default: state <= IDLE;
         endcase

         if (state inside {LOAD, TXLOAD, TXREQ, TXWAIT_HI, TXWAIT_LO, TXSHIFT})
            overrun <= rx_dv;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_conf_ctrl.sv
// Bench for conf_ctrl: one echoing instance (long timeout, UART model) and one
// non-echoing instance with TIMEOUT=20 for the timeout corner cases.
module tb_conf_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_dv_a = 1'b0, rx_dv_b = 1'b0;
   logic tx_busy_a, tx_busy_b = 1'b0;
   logic tx_start_a, shift_rx_a, load_conf_a, load_tx_a, shift_tx_a, done_a, err_a, ovr_a, busy_a;
   logic tx_start_b, shift_rx_b, load_conf_b, load_tx_b, shift_tx_b, done_b, err_b, ovr_b, busy_b;

   always #5 clk = ~clk;

   conf_ctrl #(.NUM_BYTES(11), .TIMEOUT(200), .ECHO(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv_a), .tx_busy(tx_busy_a),
      .tx_start(tx_start_a), .shift_rxregs(shift_rx_a), .load_confregs(load_conf_a),
      .load_txregs(load_tx_a), .shift_txregs(shift_tx_a), .frame_done(done_a),
      .frame_err(err_a), .overrun(ovr_a), .busy(busy_a));

   conf_ctrl #(.NUM_BYTES(11), .TIMEOUT(20), .ECHO(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv_b), .tx_busy(tx_busy_b),
      .tx_start(tx_start_b), .shift_rxregs(shift_rx_b), .load_confregs(load_conf_b),
      .load_txregs(load_tx_b), .shift_txregs(shift_tx_b), .frame_done(done_b),
      .frame_err(err_b), .overrun(ovr_b), .busy(busy_b));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_sample = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // UART transmitter model: busy for 50 cycles after each tx_start.
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start_a) busy_cnt <= 50;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy_a = (busy_cnt != 0);

   // Scoreboards: expected cycle of each shift_rxregs pulse.
   int exp_a[$];
   int exp_b[$];

   int n_shift_a, n_ld_a, n_done_a, n_ltx_a, n_stx_a, n_txs_a, n_err_a, n_ovr_a;
   int n_shift_b, n_ld_b, n_done_b, n_ltx_b, n_stx_b, n_txs_b, n_err_b, n_ovr_b;
   int done_cyc_a, ovr_cyc_a, done_cyc_b, err_cyc_b;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_counts();
      n_shift_a = 0; n_ld_a = 0; n_done_a = 0; n_ltx_a = 0;
      n_stx_a = 0; n_txs_a = 0; n_err_a = 0; n_ovr_a = 0;
      n_shift_b = 0; n_ld_b = 0; n_done_b = 0; n_ltx_b = 0;
      n_stx_b = 0; n_txs_b = 0; n_err_b = 0; n_ovr_b = 0;
      done_cyc_a = -1; ovr_cyc_a = -1; done_cyc_b = -1; err_cyc_b = -1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (shift_rx_a) begin
            n_shift_a++;
            if (exp_a.size() == 0) check("a_unexpected_shift", 1, 0);
            else check("a_shift_time", cyc, exp_a.pop_front());
         end
         if (shift_rx_b) begin
            n_shift_b++;
            if (exp_b.size() == 0) check("b_unexpected_shift", 1, 0);
            else check("b_shift_time", cyc, exp_b.pop_front());
         end
         if (load_conf_a) begin n_ld_a++; done_cyc_a = cyc; end
         if (done_a) n_done_a++;
         if (load_tx_a) n_ltx_a++;
         if (shift_tx_a) n_stx_a++;
         if (tx_start_a) n_txs_a++;
         if (err_a) n_err_a++;
         if (ovr_a) begin n_ovr_a++; ovr_cyc_a = cyc; end
         if (load_conf_b) begin n_ld_b++; done_cyc_b = cyc; end
         if (done_b) n_done_b++;
         if (load_tx_b) n_ltx_b++;
         if (shift_tx_b) n_stx_b++;
         if (tx_start_b) n_txs_b++;
         if (err_b) begin n_err_b++; err_cyc_b = cyc; end
         if (ovr_b) n_ovr_b++;
         check("a_onehot", int'($countones({shift_rx_a, load_conf_a, load_tx_a, shift_tx_a}) <= 1), 1);
         check("a_done_with_load", int'(done_a), int'(load_conf_a));
         check("b_done_with_load", int'(done_b), int'(load_conf_b));
      end
   end

   // Caller is at a negedge; strobes are gap cycles apart.
   task automatic send(input bit sel_b, input int n, input int gap, input bit expect_shift);
      for (int i = 0; i < n; i++) begin
         if (sel_b) rx_dv_b = 1'b1; else rx_dv_a = 1'b1;
         last_sample = cyc + 1;
         if (expect_shift) begin
            if (sel_b) exp_b.push_back(cyc + 1); else exp_a.push_back(cyc + 1);
         end
         @(negedge clk);
         rx_dv_a = 1'b0;
         rx_dv_b = 1'b0;
         if (i < n - 1) repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic wait_idle_a(input int budget, input string name);
      int k = 0;
      while (busy_a && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(busy_a), 0);
   endtask

   typedef struct {
      int n;
      int gap;
      int exp_done;
      int exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int k;
      int ovr_sample;
      vecs[0] = '{n: 11, gap: 5,  exp_done: 1, exp_err: 0};
      vecs[1] = '{n: 5,  gap: 4,  exp_done: 0, exp_err: 1};
      vecs[2] = '{n: 11, gap: 20, exp_done: 1, exp_err: 0};
      vecs[3] = '{n: 2,  gap: 21, exp_done: 0, exp_err: 2};
      vecs[4] = '{n: 11, gap: 1,  exp_done: 1, exp_err: 0};
      clear_counts();

      repeat (3) @(negedge clk);
      check("rst_outs_a", int'({tx_start_a, shift_rx_a, load_conf_a, load_tx_a, shift_tx_a,
                                done_a, err_a, ovr_a, busy_a}), 0);
      check("rst_outs_b", int'({tx_start_b, shift_rx_b, load_conf_b, load_tx_b, shift_tx_b,
                                done_b, err_b, ovr_b, busy_b}), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Non-echo instance: frames, timeouts and the timeout/strobe coincidence.
      for (int v = 0; v < 5; v++) begin
         clear_counts();
         send(1'b1, vecs[v].n, vecs[v].gap, 1'b1);
         repeat (45) @(negedge clk);
         check($sformatf("v%0d_shifts", v), n_shift_b, vecs[v].n);
         check($sformatf("v%0d_done", v), n_done_b, vecs[v].exp_done);
         check($sformatf("v%0d_load", v), n_ld_b, vecs[v].exp_done);
         check($sformatf("v%0d_err", v), n_err_b, vecs[v].exp_err);
         check($sformatf("v%0d_no_tx", v), n_txs_b + n_ltx_b + n_stx_b, 0);
         check($sformatf("v%0d_busy", v), int'(busy_b), 0);
         check($sformatf("v%0d_pending", v), exp_b.size(), 0);
         if (vecs[v].exp_err != 0)
            check($sformatf("v%0d_err_time", v), err_cyc_b, last_sample + 20);
         if (vecs[v].exp_done != 0)
            check($sformatf("v%0d_load_time", v), done_cyc_b, last_sample + 1);
      end

      // Full frame with echo, strobes 100 cycles apart.
      clear_counts();
      send(1'b0, 11, 100, 1'b1);
      wait_idle_a(2000, "echo_idle_wait");
      check("echo_shifts", n_shift_a, 11);
      check("echo_load", n_ld_a, 1);
      check("echo_done", n_done_a, 1);
      check("echo_load_time", done_cyc_a, last_sample + 1);
      check("echo_ltx", n_ltx_a, 1);
      check("echo_tx_start", n_txs_a, 11);
      check("echo_stx", n_stx_a, 11);
      check("echo_no_err", n_err_a + n_ovr_a, 0);
      check("echo_pending", exp_a.size(), 0);

      // Strobe during the echo.
      clear_counts();
      send(1'b0, 11, 3, 1'b1);
      k = 0;
      while (n_ltx_a < 1 && k < 100) begin @(negedge clk); k++; end
      check("ovr_reach_echo", int'(n_ltx_a >= 1), 1);
      repeat (20) @(negedge clk);
      send(1'b0, 1, 1, 1'b0);
      ovr_sample = last_sample;
      wait_idle_a(2000, "ovr_idle_wait");
      check("ovr_count", n_ovr_a, 1);
      check("ovr_time", ovr_cyc_a, ovr_sample);
      check("ovr_shifts", n_shift_a, 11);
      check("ovr_tx_start", n_txs_a, 11);
      check("ovr_stx", n_stx_a, 11);

      // Reset in the middle of the echo, then a fresh frame.
      clear_counts();
      send(1'b0, 11, 2, 1'b1);
      k = 0;
      while (n_txs_a < 3 && k < 1000) begin @(negedge clk); k++; end
      check("rst_reach_3rd_tx", int'(n_txs_a >= 3), 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", int'({tx_start_a, shift_rx_a, load_conf_a, load_tx_a, shift_tx_a,
                                  done_a, err_a, ovr_a, busy_a}), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_hold_outs", int'({tx_start_a, load_tx_a, shift_tx_a, busy_a}), 0);
      end
      rst_n = 1'b1;
      clear_counts();
      repeat (5) @(negedge clk);
      check("post_rst_quiet", n_txs_a + n_stx_a + n_ltx_a + n_ld_a + n_shift_a, 0);
      check("post_rst_busy", int'(busy_a), 0);
      send(1'b0, 11, 2, 1'b1);
      wait_idle_a(2000, "post_rst_idle_wait");
      check("post_rst_done", n_done_a, 1);
      check("post_rst_load_time", done_cyc_a, last_sample + 1);
      check("post_rst_ltx", n_ltx_a, 1);
      check("post_rst_tx_start", n_txs_a, 11);
      check("post_rst_stx", n_stx_a, 11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
